// File: rtl/bram_loader_pkg.sv
// Shared definitions for the BRAM loader.
//   bram_loader_state_t : control FSM states (IDLE, LOAD, DONE)
//   calc_ratio()        : stream beats per BRAM word
//   lane_cnt_width()    : width of the lane counter for a given ratio
package bram_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } bram_loader_state_t;

  // Number of inbound beats that make up one write word.
  function automatic int calc_ratio(input int in_width, input int write_width);
    return write_width / in_width;
  endfunction

  // Lane counter width; never narrower than one bit so a ratio of 1 still elaborates.
  function automatic int lane_cnt_width(input int ratio);
    if (ratio <= 2) begin
      return 1;
    end else begin
      return $clog2(ratio);
    end
  endfunction

endpackage

// File: rtl/bram_loader_packer.sv
// beat_packer: assembles IN_WIDTH beats into WRITE_WIDTH words, little-endian
// (lane 0 arrives first and lands in the least significant bits).
// Ports:
//   clk, rst        clock and synchronous active-low reset
//   clear           drops any partially assembled word and rewinds the lane counter
//   beat_en         a beat transfers this cycle
//   beat_data       the beat being transferred
//   word_data       assembled word; valid in the cycle word_complete is high
//   word_complete   the final lane of a word transfers this cycle
module beat_packer
  import bram_loader_pkg::*;
#(
  parameter int IN_WIDTH    = 8,
  parameter int WRITE_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  input  logic                   beat_en,
  input  logic [IN_WIDTH-1:0]    beat_data,
  output logic [WRITE_WIDTH-1:0] word_data,
  output logic                   word_complete
);

  localparam int RATIO  = calc_ratio(IN_WIDTH, WRITE_WIDTH);
  localparam int LANE_W = lane_cnt_width(RATIO);
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(RATIO - 1);

  logic [LANE_W-1:0]      lane_r;
  logic [WRITE_WIDTH-1:0] lanes_r;
  logic [WRITE_WIDTH-1:0] word_s;

  // Lane counter and storage for every lane except the last one.
  always_ff @(posedge clk) begin
    if (!rst) begin
      lane_r  <= '0;
      lanes_r <= '0;
    end else if (clear) begin
      lane_r  <= '0;
      lanes_r <= '0;
    end else if (beat_en) begin
      for (int k = 0; k < RATIO - 1; k++) begin
        if (lane_r == LANE_W'(k)) begin
          lanes_r[k*IN_WIDTH +: IN_WIDTH] <= beat_data;
        end
      end
      if (lane_r == LAST_LANE) begin
        lane_r <= '0;
      end else begin
        lane_r <= lane_r + LANE_W'(1'b1);
      end
    end
  end

  // The last lane is taken straight from the bus so the word is ready in the
  // cycle its final beat transfers, with no extra bubble.
  always_comb begin
    word_s = lanes_r;
    word_s[(RATIO-1)*IN_WIDTH +: IN_WIDTH] = beat_data;
  end

  assign word_data     = word_s;
  assign word_complete = beat_en && (lane_r == LAST_LANE);

endmodule

// File: rtl/bram_loader.sv
// bram_loader: loads a run of words from a narrow inbound stream into a BRAM
// write port, starting at base_addr and wrapping modulo the address space.
// Ports:
//   clk, rst                  clock and synchronous active-low reset
//   start, base_addr, length  load request, sampled only while idle
//   abort                     cancels an active load, dropping any partial word
//   in_valid/in_data/in_ready inbound beat handshake
//   w_addr/w_valid/w_data     BRAM write port, one-cycle write strobes
//   busy, done                status: not idle / one-cycle completion pulse
//   words_written             words committed in the current or last load
module bram_loader
  import bram_loader_pkg::*;
#(
  parameter int IN_WIDTH         = 8,
  parameter int WRITE_WIDTH      = 32,
  parameter int WRITE_ADDR_WIDTH = 10
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [WRITE_ADDR_WIDTH-1:0] base_addr,
  input  logic [WRITE_ADDR_WIDTH:0]   length,
  input  logic                        abort,
  input  logic                        in_valid,
  input  logic [IN_WIDTH-1:0]         in_data,
  output logic                        in_ready,
  output logic [WRITE_ADDR_WIDTH-1:0] w_addr,
  output logic                        w_valid,
  output logic [WRITE_WIDTH-1:0]      w_data,
  output logic                        busy,
  output logic                        done,
  output logic [WRITE_ADDR_WIDTH:0]   words_written
);

  localparam int AW = WRITE_ADDR_WIDTH;
  localparam logic [AW:0] CNT_ONE = {{AW{1'b0}}, 1'b1};

  bram_loader_state_t state_r, state_s;

  logic [AW-1:0]          base_r, base_s;
  logic [AW:0]            length_r, length_s;
  logic [AW:0]            ww_r, ww_s;
  logic                   in_ready_r, in_ready_s;
  logic                   busy_r, done_r, w_valid_r;
  logic [AW-1:0]          w_addr_r, w_addr_s;
  logic [WRITE_WIDTH-1:0] w_data_r, w_data_s;

  logic                   beat_en_s;
  logic                   pack_clear_s;
  logic                   word_complete_s;
  logic [WRITE_WIDTH-1:0] word_data_s;
  logic                   commit_s;

  assign beat_en_s    = in_valid && in_ready_r;
  // Lanes are only meaningful inside LOAD; an abort discards the partial word.
  assign pack_clear_s = (state_r != ST_LOAD) || abort;
  // A word completed in the same cycle as an abort is dropped, not written.
  assign commit_s     = word_complete_s && !abort && (state_r == ST_LOAD);

  beat_packer #(
    .IN_WIDTH    (IN_WIDTH),
    .WRITE_WIDTH (WRITE_WIDTH)
  ) u_packer (
    .clk           (clk),
    .rst           (rst),
    .clear         (pack_clear_s),
    .beat_en       (beat_en_s),
    .beat_data     (in_data),
    .word_data     (word_data_s),
    .word_complete (word_complete_s)
  );

  // Next-state logic for the load FSM.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          if (length != '0) begin
            state_s = ST_LOAD;
          end else begin
            state_s = ST_DONE;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (abort) begin
          state_s = ST_IDLE;
        end else if (ww_r == length_r) begin
          // The final word's write strobe is out this cycle.
          state_s = ST_DONE;
        end else begin
          state_s = ST_LOAD;
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Request latching, committed-word count, write port and ready for next cycle.
  always_comb begin
    base_s   = base_r;
    length_s = length_r;
    ww_s     = ww_r;
    w_addr_s = w_addr_r;
    w_data_s = w_data_r;
    if ((state_r == ST_IDLE) && start) begin
      base_s   = base_addr;
      length_s = length;
      ww_s     = '0;
    end else if (commit_s) begin
      // ww_r is the index of the word being committed.
      ww_s     = ww_r + CNT_ONE;
      w_addr_s = base_r + ww_r[AW-1:0];
      w_data_s = word_data_s;
    end else begin
      ww_s     = ww_r;
    end
    // Words accepted equals committed words, so ready drops right after the
    // final beat of the final word.
    in_ready_s = (state_s == ST_LOAD) && (ww_s < length_s);
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r    <= ST_IDLE;
      base_r     <= '0;
      length_r   <= '0;
      ww_r       <= '0;
      in_ready_r <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      w_valid_r  <= 1'b0;
      w_addr_r   <= '0;
      w_data_r   <= '0;
    end else begin
      state_r    <= state_s;
      base_r     <= base_s;
      length_r   <= length_s;
      ww_r       <= ww_s;
      in_ready_r <= in_ready_s;
      busy_r     <= (state_s != ST_IDLE);
      done_r     <= (state_s == ST_DONE);
      w_valid_r  <= commit_s;
      w_addr_r   <= w_addr_s;
      w_data_r   <= w_data_s;
    end
  end

  assign in_ready      = in_ready_r;
  assign busy          = busy_r;
  assign done          = done_r;
  assign w_valid       = w_valid_r;
  assign w_addr        = w_addr_r;
  assign w_data        = w_data_r;
  assign words_written = ww_r;

endmodule

// File: tb/tb_bram_loader.sv
// Self-checking bench for bram_loader with default parameters (8-bit beats,
// 32-bit words, 10-bit addresses).
module tb_bram_loader;

  localparam int IW = 8;
  localparam int WW = 32;
  localparam int AW = 10;
  localparam int R  = WW / IW;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0]   length = '0;
  logic          abort = 1'b0;
  logic          in_valid = 1'b0;
  logic [IW-1:0] in_data = '0;
  logic          in_ready;
  logic [AW-1:0] w_addr;
  logic          w_valid;
  logic [WW-1:0] w_data;
  logic          busy;
  logic          done;
  logic [AW:0]   words_written;

  bram_loader #(
    .IN_WIDTH         (IW),
    .WRITE_WIDTH      (WW),
    .WRITE_ADDR_WIDTH (AW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .base_addr     (base_addr),
    .length        (length),
    .abort         (abort),
    .in_valid      (in_valid),
    .in_data       (in_data),
    .in_ready      (in_ready),
    .w_addr        (w_addr),
    .w_valid       (w_valid),
    .w_data        (w_data),
    .busy          (busy),
    .done          (done),
    .words_written (words_written)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;
  int cyc_cnt = 0;
  bit rdy_seen = 1'b0;
  logic [AW-1:0] wr_addr_q[$];
  logic [WW-1:0] wr_data_q[$];
  int            wr_cyc_q[$];
  logic [IW-1:0] beats_q[$];

  // Write-port monitor, sampling just after each rising edge.
  always @(posedge clk) begin
    #1;
    if (w_valid) begin
      wr_addr_q.push_back(w_addr);
      wr_data_q.push_back(w_data);
      wr_cyc_q.push_back(cyc_cnt);
    end
    if (done) done_cnt++;
    if (in_ready) rdy_seen = 1'b1;
    cyc_cnt++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1);
  end

  // Reference: word w is beats w*R..w*R+R-1, first beat in the low bits.
  function automatic logic [WW-1:0] model_word(input int w);
    logic [WW-1:0] r;
    r = '0;
    for (int k = 0; k < R; k++) r = r | (WW'(beats_q[w*R+k]) << (IW*k));
    return r;
  endfunction

  function automatic logic [AW-1:0] model_addr(input logic [AW-1:0] base, input int w);
    return AW'((int'(base) + w) % (1 << AW));
  endfunction

  task automatic clear_mon();
    wr_addr_q.delete();
    wr_data_q.delete();
    wr_cyc_q.delete();
    done_cnt = 0;
    rdy_seen = 1'b0;
  endtask

  task automatic random_beats(input int n);
    beats_q.delete();
    for (int i = 0; i < n; i++) beats_q.push_back(IW'($urandom_range(0, 255)));
  endtask

  task automatic start_load(input logic [AW-1:0] b, input logic [AW:0] len);
    start = 1'b1;
    base_addr = b;
    length = len;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Offers beats_q in order; a beat transfers at the next rising edge when
  // in_valid and in_ready are both high at the falling edge.
  task automatic feed_beats(input int pct, input int max_cyc, output int used);
    int idx;
    idx = 0;
    used = 0;
    while (idx < beats_q.size() && used < max_cyc) begin
      in_valid = ($urandom_range(0, 99) < pct);
      in_data = beats_q[idx];
      if (in_valid && in_ready) idx++;
      @(negedge clk);
      used++;
    end
    in_valid = 1'b0;
    checks++;
    if (idx != beats_q.size()) begin
      errors++;
      $display("FAIL feed_timeout: beats sent %0d, required %0d", idx, beats_q.size());
    end
  endtask

  task automatic wait_done(input int limit);
    int c;
    c = 0;
    while (done_cnt == 0 && c < limit) begin
      @(negedge clk);
      c++;
    end
    checks++;
    if (done_cnt == 0) begin
      errors++;
      $display("FAIL done_timeout: no done within %0d cycles", limit);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({in_ready, w_valid, busy, done} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags: got %b, required 0000", {in_ready, w_valid, busy, done});
    end
    checks++;
    if (w_addr !== '0) begin
      errors++;
      $display("FAIL reset_waddr: got %h, required 000", w_addr);
    end
    checks++;
    if (w_data !== '0) begin
      errors++;
      $display("FAIL reset_wdata: got %h, required 00000000", w_data);
    end
    checks++;
    if (words_written !== '0) begin
      errors++;
      $display("FAIL reset_count: got %0d, required 0", words_written);
    end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int used;
    clear_mon();
    beats_q.delete();
    for (int i = 0; i < 8; i++) beats_q.push_back(IW'(8'h11 + i));
    start_load(10'h010, 11'd2);
    feed_beats(100, 50, used);
    wait_done(20);
    checks++;
    if (used != 8) begin
      errors++;
      $display("FAIL basic_bubbles: cycles %0d, required 8", used);
    end
    checks++;
    if (wr_data_q.size() != 2) begin
      errors++;
      $display("FAIL basic_count: writes %0d, required 2", wr_data_q.size());
    end else begin
      for (int w = 0; w < 2; w++) begin
        checks++;
        if (wr_data_q[w] !== model_word(w) || wr_addr_q[w] !== model_addr(10'h010, w)) begin
          errors++;
          $display("FAIL basic_write%0d: got %h@%h, required %h@%h", w, wr_data_q[w],
                   wr_addr_q[w], model_word(w), model_addr(10'h010, w));
        end
      end
      checks++;
      if (wr_data_q[0] !== 32'h14131211 || wr_data_q[1] !== 32'h18171615) begin
        errors++;
        $display("FAIL basic_const: got %h %h, required 14131211 18171615", wr_data_q[0], wr_data_q[1]);
      end
      checks++;
      if (wr_cyc_q[1] - wr_cyc_q[0] != R) begin
        errors++;
        $display("FAIL basic_spacing: got %0d cycles, required %0d", wr_cyc_q[1] - wr_cyc_q[0], R);
      end
    end
    checks++;
    if (done_cnt != 1) begin
      errors++;
      $display("FAIL basic_done: pulses %0d, required 1", done_cnt);
    end
    checks++;
    if (words_written !== 11'd2 || busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_final: words %0d busy %b, required 2 0", words_written, busy);
    end
  endtask

  task automatic test_wrap();
    int used;
    clear_mon();
    random_beats(8);
    start_load(10'h3FF, 11'd2);
    feed_beats(100, 50, used);
    wait_done(20);
    checks++;
    if (wr_addr_q.size() != 2) begin
      errors++;
      $display("FAIL wrap_count: writes %0d, required 2", wr_addr_q.size());
    end else begin
      checks++;
      if (wr_addr_q[0] !== 10'h3FF || wr_addr_q[1] !== 10'h000) begin
        errors++;
        $display("FAIL wrap_addr: got %h %h, required 3ff 000", wr_addr_q[0], wr_addr_q[1]);
      end
      checks++;
      if (wr_data_q[1] !== model_word(1)) begin
        errors++;
        $display("FAIL wrap_data: got %h, required %h", wr_data_q[1], model_word(1));
      end
    end
  endtask

  task automatic test_zero_len();
    clear_mon();
    start_load(AW'($urandom_range(0, 1023)), 11'd0);
    checks++;
    if (done !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL zero_done: done %b busy %b, required 1 1", done, busy);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL zero_idle: done %b busy %b, required 0 0", done, busy);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (wr_data_q.size() != 0 || rdy_seen || done_cnt != 1) begin
      errors++;
      $display("FAIL zero_quiet: writes %0d ready_seen %b done %0d, required 0 0 1",
               wr_data_q.size(), rdy_seen, done_cnt);
    end
  endtask

  task automatic test_gaps();
    int used;
    int len;
    int pct;
    logic [AW-1:0] b;
    for (int it = 0; it < 4; it++) begin
      clear_mon();
      len = (it == 0) ? 4 : $urandom_range(1, 6);
      pct = (it == 0) ? 50 : $urandom_range(30, 100);
      b = AW'($urandom_range(0, 1023));
      random_beats(len * R);
      start_load(b, (AW+1)'(len));
      feed_beats(pct, 600, used);
      wait_done(20);
      checks++;
      if (wr_data_q.size() != len) begin
        errors++;
        $display("FAIL gaps%0d_count: writes %0d, required %0d", it, wr_data_q.size(), len);
      end else begin
        for (int w = 0; w < len; w++) begin
          checks++;
          if (wr_data_q[w] !== model_word(w) || wr_addr_q[w] !== model_addr(b, w)) begin
            errors++;
            $display("FAIL gaps%0d_write%0d: got %h@%h, required %h@%h", it, w, wr_data_q[w],
                     wr_addr_q[w], model_word(w), model_addr(b, w));
          end
        end
      end
      checks++;
      if (done_cnt != 1 || words_written !== (AW+1)'(len)) begin
        errors++;
        $display("FAIL gaps%0d_final: done %0d words %0d, required 1 %0d", it, done_cnt, words_written, len);
      end
    end
  endtask

  task automatic test_ignore_start();
    int used;
    clear_mon();
    random_beats(4);
    start_load(10'h020, 11'd1);
    start = 1'b1;
    base_addr = 10'h100;
    length = 11'd5;
    feed_beats(100, 50, used);
    start = 1'b0;
    wait_done(20);
    checks++;
    if (wr_data_q.size() != 1) begin
      errors++;
      $display("FAIL ignore_count: writes %0d, required 1", wr_data_q.size());
    end else begin
      checks++;
      if (wr_addr_q[0] !== 10'h020 || wr_data_q[0] !== model_word(0)) begin
        errors++;
        $display("FAIL ignore_write: got %h@%h, required %h@020", wr_data_q[0], wr_addr_q[0], model_word(0));
      end
    end
    checks++;
    if (words_written !== 11'd1) begin
      errors++;
      $display("FAIL ignore_words: got %0d, required 1", words_written);
    end
  endtask

  task automatic test_abort();
    int used;
    logic [AW-1:0] b;
    clear_mon();
    b = AW'($urandom_range(0, 1023));
    random_beats(6);
    start_load(b, 11'd3);
    feed_beats(100, 50, used);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL abort_idle: busy %b ready %b, required 0 0", busy, in_ready);
    end
    repeat (6) @(negedge clk);
    checks++;
    if (wr_data_q.size() != 1) begin
      errors++;
      $display("FAIL abort_count: writes %0d, required 1", wr_data_q.size());
    end else begin
      checks++;
      if (wr_data_q[0] !== model_word(0) || wr_addr_q[0] !== b) begin
        errors++;
        $display("FAIL abort_write: got %h@%h, required %h@%h", wr_data_q[0], wr_addr_q[0], model_word(0), b);
      end
    end
    checks++;
    if (done_cnt != 0 || words_written !== 11'd1) begin
      errors++;
      $display("FAIL abort_final: done %0d words %0d, required 0 1", done_cnt, words_written);
    end
  endtask

  task automatic test_reset_mid();
    int used;
    logic [AW-1:0] b;
    clear_mon();
    random_beats(3);
    start_load(AW'($urandom_range(0, 1023)), 11'd2);
    feed_beats(100, 50, used);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (wr_data_q.size() != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_quiet: writes %0d busy %b, required 0 0", wr_data_q.size(), busy);
    end
    clear_mon();
    b = AW'($urandom_range(0, 1023));
    beats_q.delete();
    for (int i = 0; i < 4; i++) beats_q.push_back(IW'(8'hA0 + i));
    start_load(b, 11'd1);
    feed_beats(100, 50, used);
    wait_done(20);
    checks++;
    if (wr_data_q.size() != 1) begin
      errors++;
      $display("FAIL rstmid_count: writes %0d, required 1", wr_data_q.size());
    end else begin
      checks++;
      if (wr_data_q[0] !== 32'hA3A2A1A0 || wr_addr_q[0] !== b) begin
        errors++;
        $display("FAIL rstmid_write: got %h@%h, required a3a2a1a0@%h", wr_data_q[0], wr_addr_q[0], b);
      end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_basic();
    test_wrap();
    test_zero_len();
    test_gaps();
    test_ignore_start();
    test_abort();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
